// File: rtl/tracker_sequencer_pkg.sv
// Shared tracker types: note row layout, instrument/effect codes,
// sequencer states and the phase-step speed derivation.
package tracker_pkg;

  typedef struct packed {
    logic [3:0] volume;
    logic [1:0] instr;
    logic [3:0] effect;
    logic [2:0] octave;
    logic [2:0] tone;
  } note_tp;

  localparam logic [1:0] INSTR_SQUARE = 2'd0;
  localparam logic [1:0] INSTR_SAW    = 2'd1;
  localparam logic [1:0] INSTR_TRI    = 2'd2;
  localparam logic [1:0] INSTR_NOISE  = 2'd3;

  localparam logic [3:0] EFF_NONE     = 4'd0;
  localparam logic [3:0] EFF_ARP      = 4'd1;
  localparam logic [3:0] EFF_SLIDE_UP = 4'd2;
  localparam logic [3:0] EFF_SLIDE_DN = 4'd3;
  localparam logic [3:0] EFF_VIBRATO  = 4'd4;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_PLAY
  } seq_state_e;

  // (tone+1) << octave needs 11 bits at tone=7, octave=7
  function automatic logic [10:0] calc_speed(
    note_tp      n,
    int unsigned max_speed
  );
    logic [10:0] raw;
    logic [10:0] lim;
    raw = ({8'd0, n.tone} + 11'd1) << n.octave;
    lim = 11'(max_speed - 1);
    return (raw > lim) ? lim : raw;
  endfunction

endpackage

// File: rtl/tracker_sequencer_if.sv
// Control/pattern-write side and note/speed side of the sequencer.
interface tracker_sequencer_if #(
  parameter int ALEN  = 6,
  parameter int SPLEN = 4
);
  logic             start;
  logic             stop;
  logic             loop;
  logic [ALEN-1:0]  last_row;
  logic [3:0]       tempo;
  logic             wr_en;
  logic [ALEN-1:0]  wr_addr;
  logic [15:0]      wr_data;
  logic [15:0]      note_out;
  logic [SPLEN-1:0] speed_out;
  logic [ALEN-1:0]  row;
  logic             playing;
  logic             row_strobe;
  logic             done;

  modport master (
    output start, stop, loop, last_row, tempo,
    output wr_en, wr_addr, wr_data,
    input  note_out, speed_out, row,
    input  playing, row_strobe, done
  );

  modport slave (
    input  start, stop, loop, last_row, tempo,
    input  wr_en, wr_addr, wr_data,
    output note_out, speed_out, row,
    output playing, row_strobe, done
  );
endinterface

// File: rtl/tracker_sequencer_pattern_ram.sv
// Pattern storage: one write port, one synchronous read port,
// read-before-write on a same-address collision.
module pattern_ram
  import tracker_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int ALEN  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [ALEN-1:0] wr_addr,
  input  note_tp          wr_data,
  input  logic [ALEN-1:0] rd_addr,
  output note_tp          rd_data
);

  note_tp mem [DEPTH];
  note_tp rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/tracker_sequencer.sv
// Pattern sequencer: steps pattern rows at a programmable tempo and
// presents each row's note plus derived speed to the tracker voice.
module tracker_sequencer
  import tracker_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int ALEN     = $clog2(DEPTH),
  parameter int TICK_DIV = 1024,
  parameter int MAXSPEED = 16,
  parameter int SPLEN    = $clog2(MAXSPEED)
) (
  input logic clk,
  input logic rst_n,
  tracker_sequencer_if.slave bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(TICK_DIV - 1);

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [3:0]       tick_q, tick_d;
  note_tp           note_q, note_d;
  logic [SPLEN-1:0] speed_q, speed_d;
  logic [ALEN-1:0]  row_q, row_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             play_q, play_d;

  logic [ALEN-1:0]  rd_addr;
  logic [ALEN-1:0]  next_row;
  logic [3:0]       tempo_eff;
  note_tp           rd_note;

  pattern_ram #(
    .DEPTH (DEPTH),
    .ALEN  (ALEN)
  ) u_ram (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_note)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    tick_d    = tick_q;
    note_d    = note_q;
    speed_d   = speed_q;
    row_d     = row_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    next_row  = (row_q == bus.last_row) ? '0
              : ALEN'(row_q + 1'b1);
    tempo_eff = (bus.tempo == 4'd0) ? 4'd1 : bus.tempo;
    // prefetch the following row so a boundary costs no cycle
    rd_addr   = (state_q == SEQ_PLAY && !bus.start)
              ? next_row : '0;

    unique case (state_q)
      SEQ_IDLE: begin
        if (bus.start) state_d = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        state_d  = SEQ_PLAY;
        note_d   = rd_note;
        speed_d  = SPLEN'(calc_speed(rd_note, MAXSPEED));
        row_d    = '0;
        strobe_d = 1'b1;
        cyc_d    = '0;
        tick_d   = '0;
      end
      SEQ_PLAY: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if ({1'b0, tick_q} + 5'd1 >= {1'b0, tempo_eff}) begin
            tick_d = '0;
            if (row_q != bus.last_row || bus.loop) begin
              note_d   = rd_note;
              speed_d  = SPLEN'(calc_speed(rd_note, MAXSPEED));
              row_d    = next_row;
              strobe_d = 1'b1;
            end else begin
              state_d = SEQ_IDLE;
              note_d  = '0;
              speed_d = '0;
              done_d  = 1'b1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end else begin
          cyc_d = CW'(cyc_q + 1'b1);
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    if (bus.start && state_q != SEQ_IDLE) begin
      state_d  = SEQ_FETCH;
      note_d   = note_q;
      speed_d  = speed_q;
      row_d    = row_q;
      strobe_d = 1'b0;
      done_d   = 1'b0;
    end

    if (bus.stop) begin
      state_d  = SEQ_IDLE;
      note_d   = '0;
      speed_d  = '0;
      strobe_d = 1'b0;
      done_d   = 1'b0;
    end

    play_d = (state_d == SEQ_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEQ_IDLE;
      cyc_q    <= '0;
      tick_q   <= '0;
      note_q   <= '0;
      speed_q  <= '0;
      row_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      play_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      tick_q   <= tick_d;
      note_q   <= note_d;
      speed_q  <= speed_d;
      row_q    <= row_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      play_q   <= play_d;
    end
  end

  assign bus.note_out   = note_q;
  assign bus.speed_out  = speed_q;
  assign bus.row        = row_q;
  assign bus.playing    = play_q;
  assign bus.row_strobe = strobe_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_tracker_sequencer.sv
// Bench for tracker_sequencer: row scoreboard checked on every
// row_strobe, plus per-scenario checks of done/stop/reset behaviour.
module tb_tracker_sequencer;
  import tracker_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    logic [15:0] note;
    logic [3:0]  speed;
    logic [5:0]  row;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [15:0] shadow [64];

  tracker_sequencer_if #(.ALEN(6), .SPLEN(4)) bus ();

  tracker_sequencer #(
    .DEPTH    (64),
    .TICK_DIV (4),
    .MAXSPEED (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.row_strobe) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected cyc=%0d row=%0d",
                 cyc, bus.row);
      end else begin
        e = q.pop_front();
        if (bus.note_out !== e.note || bus.speed_out !== e.speed ||
            bus.row !== e.row || cyc != e.cyc) begin
          bad++;
          $display({"FAIL row_check got note=%h spd=%0d row=%0d ",
                    "cyc=%0d want note=%h spd=%0d row=%0d cyc=%0d"},
                   bus.note_out, bus.speed_out, bus.row, cyc,
                   e.note, e.speed, e.row, e.cyc);
        end
      end
    end
  end

  function automatic logic [15:0] mk(int vol, int oct, int tone);
    note_tp t;
    t        = '0;
    t.volume = 4'(vol);
    t.octave = 3'(oct);
    t.tone   = 3'(tone);
    return t;
  endfunction

  function automatic logic [3:0] exp_speed(logic [15:0] n);
    note_tp t;
    int     v;
    t = n;
    v = (int'(t.tone) + 1) << t.octave;
    if (v > 15) v = 15;
    return 4'(v);
  endfunction

  task automatic push_row(int r, int c);
    exp_t x;
    x.note  = shadow[r];
    x.speed = exp_speed(shadow[r]);
    x.row   = 6'(r);
    x.cyc   = c;
    q.push_back(x);
  endtask

  task automatic wr_row(int r, logic [15:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 6'(r);
    bus.wr_data = d;
    shadow[r]   = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic setup(int tmp, logic lp);
    for (int i = 0; i < 4; i++) wr_row(i, mk(8, 0, i));
    bus.last_row = 6'd3;
    bus.tempo    = 4'(tmp);
    bus.loop     = lp;
  endtask

  task automatic wait_done(int lim, output int dc);
    dc = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic check_idle(string nm);
    total++;
    if (bus.playing !== 1'b0 || bus.note_out !== 16'h0 ||
        bus.speed_out !== 4'h0) begin
      bad++;
      $display("FAIL %s got play=%b note=%h spd=%0d want 0/0/0",
               nm, bus.playing, bus.note_out, bus.speed_out);
    end
  endtask

  task automatic check_q_empty(string nm);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s got pending=%0d want 0", nm, q.size());
    end
    q.delete();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop     = 1'b0;
    bus.last_row = '0;
    bus.tempo    = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.note_out, bus.speed_out, bus.row, bus.playing,
         bus.row_strobe, bus.done} !== 29'h0) begin
      bad++;
      $display("FAIL reset_outputs got note=%h spd=%0d row=%0d want 0",
               bus.note_out, bus.speed_out, bus.row);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_idle");
  endtask

  task automatic test_oneshot();
    int s;
    int dc;
    setup(2, 1'b0);
    pulse_start(s);
    for (int k = 0; k < 4; k++) push_row(k, s + 2 + 8 * k);
    wait_done(80, dc);
    total++;
    if (dc != s + 34) begin
      bad++;
      $display("FAIL oneshot_done got cyc=%0d want %0d", dc, s + 34);
    end
    check_idle("oneshot_silent");
    repeat (12) @(negedge clk);
    check_q_empty("oneshot_rows");
  endtask

  task automatic test_loop();
    int s;
    bit seen;
    seen = 0;
    setup(2, 1'b1);
    pulse_start(s);
    for (int k = 0; k < 6; k++) push_row(k % 4, s + 2 + 8 * k);
    for (int i = 0; i < 80 && cyc < s + 43; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL loop_no_done got done=1 want 0");
    end
    check_q_empty("loop_rows");
    pulse_stop();
    check_idle("loop_stop");
  endtask

  task automatic test_speed();
    int s;
    int dc;
    wr_row(0, mk(5, 1, 2));
    wr_row(1, mk(5, 0, 7));
    wr_row(2, mk(5, 2, 3));
    wr_row(3, mk(5, 7, 7));
    bus.tempo = 4'd1;
    bus.loop  = 1'b0;
    pulse_start(s);
    for (int k = 0; k < 4; k++) push_row(k, s + 2 + 4 * k);
    wait_done(40, dc);
    total++;
    if (dc != s + 18) begin
      bad++;
      $display("FAIL speed_done got cyc=%0d want %0d", dc, s + 18);
    end
    repeat (6) @(negedge clk);
    check_q_empty("speed_rows");
  endtask

  task automatic test_stop();
    int s;
    bit seen;
    seen = 0;
    setup(2, 1'b0);
    pulse_start(s);
    push_row(0, s + 2);
    push_row(1, s + 10);
    for (int i = 0; i < 20 && cyc < s + 9; i++) @(negedge clk);
    pulse_stop();
    check_idle("stop_silent");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL stop_no_done got done=1 want 0");
    end
    check_q_empty("stop_rows");
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (6) @(negedge clk);
    check_idle("start_stop_idle");
  endtask

  task automatic test_tempo0_write();
    int s;
    int dc;
    setup(0, 1'b0);
    pulse_start(s);
    push_row(0, s + 2);
    push_row(1, s + 6);
    wr_row(2, mk(9, 1, 5));
    push_row(2, s + 10);
    push_row(3, s + 14);
    wait_done(40, dc);
    total++;
    if (dc != s + 18) begin
      bad++;
      $display("FAIL tempo0_done got cyc=%0d want %0d", dc, s + 18);
    end
    repeat (6) @(negedge clk);
    check_q_empty("tempo0_rows");
  endtask

  task automatic test_async_reset();
    int s;
    setup(2, 1'b1);
    pulse_start(s);
    push_row(0, s + 2);
    for (int i = 0; i < 20 && cyc < s + 5; i++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.note_out, bus.speed_out, bus.row, bus.playing,
         bus.row_strobe, bus.done} !== 29'h0) begin
      bad++;
      $display("FAIL async_reset got note=%h spd=%0d play=%b want 0",
               bus.note_out, bus.speed_out, bus.playing);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_idle("post_reset_idle");
    check_q_empty("async_rows");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_oneshot();
    test_loop();
    test_speed();
    test_stop();
    test_tempo0_write();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tracker_sequencer.md
Name: tracker_sequencer

Overview:
Pattern sequencer that drives the tracker's note and speed inputs. It holds a pattern of DEPTH note_tp rows in an internal RAM that can be written at any time. On start it steps through rows 0..last_row at a programmable tempo, optionally looping, and presents each row's note plus a derived phase-step speed. It sits between the control/CPU side and the tracker synth voice.

Parameters:
DEPTH, 64, number of pattern rows
ALEN, $clog2(DEPTH), row index width
TICK_DIV, 1024, clk cycles per tick (>=2)
MAXSPEED, 16, tracker speed range
SPLEN, $clog2(MAXSPEED), speed width

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: (re)start playback at row 0
stop  in  1  single-cycle pulse: stop playback
loop  in  1  1 = wrap to row 0 after last_row; sampled at each row boundary
last_row  in  ALEN  index of final row (pattern length = last_row+1)
tempo  in  4  ticks per row; 0 is treated as 1
wr_en  in  1  pattern RAM write strobe
wr_addr  in  ALEN  write row index
wr_data  in  16  note_tp row contents
note_out  out  16  current note_tp presented to tracker
speed_out  out  SPLEN  tracker speed for current row
row  out  ALEN  index of row currently presented
playing  out  1  high in PLAY state
row_strobe  out  1  one-cycle pulse when a new row is loaded
done  out  1  one-cycle pulse when a non-looping pattern ends

Behaviour:
- Reset (async, rst_n low): state IDLE; note_out=0, speed_out=0, row=0, playing=0, row_strobe=0, done=0, tick and row counters 0. RAM contents undefined.
- States: IDLE, FETCH, PLAY.
- IDLE: note_out held at 0 (volume 0 = silence), speed_out=0. start -> FETCH, RAM read address = 0.
- FETCH (one cycle): RAM sync read of row 0 completes; -> PLAY, load note_out/speed_out, row=0, row_strobe=1. Result: start sampled at cycle N gives note_out valid and row_strobe at cycle N+2.
- PLAY: cycle counter counts 0..TICK_DIV-1; at wrap, tick counter increments; row boundary when tick counter reaches max(tempo,1) (i.e. each row lasts exactly max(tempo,1)*TICK_DIV cycles).
- Prefetch: in PLAY the RAM read address is always next_row (row+1, or 0 if row==last_row), so the boundary needs no extra cycle.
- At a boundary: if row!=last_row, load next row, row_strobe=1. If row==last_row and loop=1, load row 0, row_strobe=1. If row==last_row and loop=0, go IDLE, done=1, note_out=0, speed_out=0.
- tempo or last_row changes mid-play take effect at the next comparison. If last_row is lowered below row, playback continues incrementing until row wraps through DEPTH-1 to 0; no special handling.
- stop in any state: IDLE next cycle, outputs silenced, no done pulse. start+stop in the same cycle: stop wins. start in PLAY/FETCH: restart via FETCH at row 0.
- Writes: accepted in any state, take one cycle. A write to a row is guaranteed visible if it completes at least 2 cycles before that row is loaded. Write and read of the same address in the same cycle return old data.
- Speed: speed_out = min(MAXSPEED-1, (tone+1) << octave), computed in an 11-bit intermediate, then saturated. It is registered together with note_out.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package tracker_pkg: note_tp typedef, INSTR_* and EFF_* constants, sequencer state enum, speed-derivation function.
- One sub-module: pattern_ram (DEPTH x 16, one write port, one synchronous read port). The tracker module imports tracker_pkg instead of defining note_tp locally.

Test Plan:
- TICK_DIV=4. Write rows 0..3 with tones 0..3 at octave 0, last_row=3, tempo=2, loop=0, start at cycle 10 -> row 0 appears at cycle 12. Rows change every 8 cycles with speed 1,2,3,4. done pulses at cycle 44, then note_out=0 and playing=0.
- Same setup with loop=1 -> after row 3 the row sequence is 0,1,...; row_strobe every 8 cycles; done is never asserted.
- Speed saturation: tone=2,oct=1 -> 6; tone=7,oct=0 -> 8; tone=3,oct=2 -> 15 (saturated from 16); tone=7,oct=7 -> 15.
- stop at cycle 20 during row 1 -> IDLE at cycle 21 with note_out=0, no done. start and stop in the same cycle -> remains IDLE.
- tempo=0 -> each row lasts 4 cycles (same as tempo=1). Write new data to row 2 while row 0 is playing -> row 2 plays the new data.
- Assert rst_n low mid-row -> all outputs are 0 immediately (asynchronously). After release, the block stays IDLE until start.
